hamming_codec_arbiter: RTL and testbench
========================================

HAMMING_CODEC_ARBITER -- requirements
Module: hamming_codec_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating error counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  2  request per requester 0/1, held until granted.
REQ-005 SHALL have port op  input  2  per-requester operation: 0 encode, 1 decode.
REQ-006 SHALL have ports wdata0, wdata1  input  16  operands (encode uses [10:0]; decode uses full codeword).
REQ-007 SHALL have port gnt  output  2  one-hot grant, one-cycle pulse.
REQ-008 SHALL have ports rsp_valid (1), rsp_id (1), rsp_data (16), rsp_status (2)  output  result for granted requester.
REQ-009 SHALL have ports clr_cnt  input  1  and corr_cnt, dbl_cnt  output  CNT_W  error statistics.
REQ-010 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight at a time.
REQ-012 IDLE with any req bit set at an edge SHALL enter EXEC, latch winner's op and wdata, assert gnt[winner] for exactly that EXEC cycle.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; pointer favours 0 after reset.
REQ-014 EXEC SHALL register the codec result and enter RESP; RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-015 Latency SHALL be: req sampled at edge k, gnt high cycle k..k+1, rsp_valid high cycle k+1..k+2; max throughput one op per 3 cycles.
REQ-016 req SHALL be ignored outside IDLE; a requester still asserting req in RESP is considered in the next IDLE.
REQ-017 Codeword layout SHALL be: p1@1, p2@2, d0@3, p4@4, d1..d3@5..7, p8@8, d4..d10@9..15, bit0 = even parity over bits 15:1.
REQ-018 Parity p1/p2/p4/p8 SHALL equal the XOR of the 4-bit positions of all set data bits.
REQ-019 Encode SHALL return the 16-bit codeword, status 00.
REQ-020 Decode SHALL compute syndrome = XOR of positions of set bits 15:1 and overall = XOR of all 16 bits.
REQ-021 Decode: syndrome 0, overall 0 -> status 00; overall 1 -> flip bit[syndrome] (bit0 if syndrome 0), status 01; syndrome nonzero, overall 0 -> status 10, no correction.
REQ-022 Decode rsp_data SHALL be {5'b0, extracted data[10:0]}.
REQ-023 corr_cnt/dbl_cnt SHALL increment in the RESP cycle for status 01/10, saturate at all-ones, never wrap.
REQ-024 clr_cnt SHALL zero both counters next edge and take priority over a same-cycle increment.
REQ-025 rsp_data, rsp_id, rsp_status SHALL hold their last value outside RESP.

Reset
REQ-026 rst SHALL immediately force IDLE, gnt 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_status 00, busy 0, counters 0, RR pointer favouring 0.
REQ-027 rst during EXEC or RESP SHALL abort the operation with no rsp_valid produced.

Structure
REQ-028 Package hamming_pkg SHALL hold op codes, status codes (OK, CORR, DBL), data-to-position table, data/codeword widths.
REQ-029 A combinational sub-module hamming_secded_codec SHALL perform encode/decode; the arbiter owns all state.

Verification
REQ-030 Encode 11'h42D on requester 0 -> gnt=01, rsp_data 16'h84DE, status 00, rsp_id 0, two cycles after req sample.
REQ-031 Decode 16'h80DE (bit10 flipped) -> rsp_data 16'h042D, status 01, corr_cnt 1.
REQ-032 Decode 16'h84D8 (bits 1,2 flipped) -> status 10, dbl_cnt 1, corr_cnt unchanged.
REQ-033 Both req held from reset -> grants alternate 01, 10, 01; rsp_id 0,1,0; 3-cycle spacing.
REQ-034 rst pulsed during EXEC -> no rsp_valid, busy 0, counters 0; next request served normally.
REQ-035 260 single-error decodes -> corr_cnt 255; clr_cnt with a simultaneous corrected response -> 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, op/status codes and data-to-position table
// for the Hamming SECDED codec arbiter.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_CORR = 2'b01,
    ST_DBL  = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Entry i (4 bits, LSB first) is the codeword position of data bit i.
  localparam logic [4*DATA_W-1:0] DATA_POS_TBL = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

  function automatic logic [3:0] data_pos(input int i);
    return DATA_POS_TBL[i*4 +: 4];
  endfunction

endpackage

// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - combinational (16,11) SECDED encoder/decoder.
module hamming_secded_codec
  import hamming_pkg::*;
(
  input  logic              op,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output status_e           status
);

  logic [CODE_W-1:0] enc_word;
  logic [CODE_W-1:0] fixed_word;
  logic [DATA_W-1:0] dec_data;
  logic [3:0]        par;
  logic [3:0]        syn;
  logic              overall;
  status_e           dec_status;

  always_comb begin
    enc_word = '0;
    par      = '0;
    for (int i = 0; i < DATA_W; i++) begin
      enc_word[data_pos(i)] = din[i];
      if (din[i]) par ^= data_pos(i);
    end
    enc_word[1] = par[0];
    enc_word[2] = par[1];
    enc_word[4] = par[2];
    enc_word[8] = par[3];
    enc_word[0] = ^enc_word[CODE_W-1:1];
  end

  always_comb begin
    syn = '0;
    for (int b = 1; b < CODE_W; b++) begin
      if (din[b]) syn ^= 4'(b);
    end
    overall    = ^din;
    fixed_word = din;
    dec_status = ST_OK;
    // Odd overall parity means a single error; syndrome 0 then points at bit 0.
    if (overall) begin
      fixed_word[syn] = ~din[syn];
      dec_status      = ST_CORR;
    end else if (syn != 4'd0) begin
      dec_status = ST_DBL;
    end
    for (int i = 0; i < DATA_W; i++) begin
      dec_data[i] = fixed_word[data_pos(i)];
    end
  end

  always_comb begin
    dout   = enc_word;
    status = ST_OK;
    if (op == OP_DEC) begin
      dout   = {{(CODE_W-DATA_W){1'b0}}, dec_data};
      status = dec_status;
    end
  end

endmodule

// File: rtl/hamming_codec_arbiter.sv
// rtl/hamming_codec_arbiter.sv - two-requester round-robin front end for the
// SECDED codec with registered responses and saturating error counters.
module hamming_codec_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        op,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  output logic [1:0]        gnt,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [15:0]       rsp_data,
  output logic [1:0]        rsp_status,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  dbl_cnt,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              op_q, op_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              id_q, id_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  status_e           rsp_status_q, rsp_status_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  dbl_cnt_q, dbl_cnt_d;
  logic              win;
  logic [15:0]       codec_data;
  status_e           codec_status;

  hamming_secded_codec u_codec (
    .op     (op_q),
    .din    (wdata_q),
    .dout   (codec_data),
    .status (codec_status)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    gnt_d        = 2'b00;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    win          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // prio_q names the requester that was not granted last.
          win     = (req == 2'b11) ? prio_q : req[1];
          state_d = S_EXEC;
          id_d    = win;
          op_d    = op[win];
          wdata_d = win ? wdata1 : wdata0;
          gnt_d   = win ? 2'b10 : 2'b01;
          prio_d  = ~win;
        end
      end
      S_EXEC: begin
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_data_d   = codec_data;
        rsp_status_d = codec_status;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    corr_cnt_d = corr_cnt_q;
    dbl_cnt_d  = dbl_cnt_q;
    if (clr_cnt) begin
      corr_cnt_d = '0;
      dbl_cnt_d  = '0;
    end else if (state_q == S_RESP) begin
      if (rsp_status_q == ST_CORR && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (rsp_status_q == ST_DBL && dbl_cnt_q != '1)   dbl_cnt_d  = dbl_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      op_q         <= 1'b0;
      wdata_q      <= '0;
      id_q         <= 1'b0;
      gnt_q        <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      corr_cnt_q   <= '0;
      dbl_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      corr_cnt_q   <= corr_cnt_d;
      dbl_cnt_q    <= dbl_cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign corr_cnt   = corr_cnt_q;
  assign dbl_cnt    = dbl_cnt_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// tb/tb_hamming_codec_arbiter.sv - self-checking bench for hamming_codec_arbiter:
// directed vector table, round-robin/reset/saturation sequences, random ops vs. model.
module tb_hamming_codec_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  op = 2'b00;
  logic [15:0] wdata0 = '0;
  logic [15:0] wdata1 = '0;
  logic        clr_cnt = 1'b0;
  logic [1:0]  gnt;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [7:0]  corr_cnt;
  logic [7:0]  dbl_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int m_corr = 0;
  int m_dbl  = 0;
  logic mdl_last = 1'b1;

  hamming_codec_arbiter #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .op         (op),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .dbl_cnt    (dbl_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  r;
    logic [1:0]  o;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [1:0]  g;
    logic [15:0] d;
    logic [1:0]  s;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Reference encoder: fill non-power-of-two slots, then set parity so the
  // XOR of set positions becomes zero, then make total parity even.
  function automatic logic [15:0] m_encode(input logic [10:0] d);
    logic [15:0] cw;
    int k;
    int s;
    cw = '0;
    k  = 0;
    s  = 0;
    for (int p = 1; p < 16; p++) begin
      if (!is_pow2(p)) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p++) if (cw[p]) s ^= p;
    for (int b = 0; b < 4; b++) if (s[b]) cw[1 << b] = 1'b1;
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] m_extract(input logic [15:0] cw);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if (!is_pow2(p)) begin
        d[k] = cw[p];
        k++;
      end
    end
    return d;
  endfunction

  // Nearest-codeword decoder: exact match, else any single flip, else double.
  task automatic m_decode(input logic [15:0] w, output logic [15:0] d, output logic [1:0] s);
    logic [15:0] t;
    d = {5'b0, m_extract(w)};
    s = 2'b10;
    if (m_encode(m_extract(w)) == w) begin
      s = 2'b00;
    end else begin
      for (int i = 0; i < 16; i++) begin
        t = w ^ (16'h1 << i);
        if (m_encode(m_extract(t)) == t) begin
          d = {5'b0, m_extract(t)};
          s = 2'b01;
        end
      end
    end
  endtask

  task automatic transact(input logic [1:0] r, input logic [1:0] o, input logic [15:0] w0,
                          input logic [15:0] w1, input logic [1:0] eg, input logic [15:0] ed,
                          input logic [1:0] es);
    int n;
    req = r; op = o; wdata0 = w0; wdata1 = w1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 6);
    check("gnt_latency", n, 1);
    check("gnt", gnt, eg);
    check("busy_exec", busy, 1'b1);
    req = 2'b00;
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1'b1);
    check("gnt_pulse", gnt, 2'b00);
    check("rsp_id", rsp_id, eg[1]);
    check("rsp_data", rsp_data, ed);
    check("rsp_status", rsp_status, es);
    mdl_last = eg[1];
    if (es == 2'b01 && m_corr < 255) m_corr++;
    if (es == 2'b10 && m_dbl < 255)  m_dbl++;
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("rsp_data_hold", rsp_data, ed);
    check("corr_cnt", corr_cnt, m_corr);
    check("dbl_cnt", dbl_cnt, m_dbl);
  endtask

  initial begin
    logic [1:0]  r, o, eg, es;
    logic [15:0] w0, w1, wsel, ed;
    logic        win;

    tbl[0] = '{2'b01, 2'b00, 16'h042D, 16'h0000, 2'b01, 16'h84DE, 2'b00};
    tbl[1] = '{2'b01, 2'b01, 16'h80DE, 16'h0000, 2'b01, 16'h042D, 2'b01};
    tbl[2] = '{2'b01, 2'b01, 16'h84D8, 16'h0000, 2'b01, 16'h042D, 2'b10};
    tbl[3] = '{2'b10, 2'b10, 16'h0000, 16'h84DE, 2'b10, 16'h042D, 2'b00};
    tbl[4] = '{2'b10, 2'b00, 16'h0000, 16'h0000, 2'b10, 16'h0000, 2'b00};
    tbl[5] = '{2'b01, 2'b01, 16'h84DF, 16'h0000, 2'b01, 16'h042D, 2'b01};
    tbl[6] = '{2'b10, 2'b00, 16'h0000, 16'h07FF, 2'b10, 16'hFFFF, 2'b00};
    tbl[7] = '{2'b10, 2'b10, 16'h0000, 16'hFFFF, 2'b10, 16'h07FF, 2'b00};
    tbl[8] = '{2'b10, 2'b10, 16'h0000, 16'h7FFF, 2'b10, 16'h07FF, 2'b01};
    tbl[9] = '{2'b01, 2'b01, 16'hFFFC, 16'h0000, 2'b01, 16'h07FF, 2'b10};

    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_rsp_status", rsp_status, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_corr", corr_cnt, 0);
    check("rst_dbl", dbl_cnt, 0);

    // Both requesters held from reset: grants alternate every three cycles.
    rst = 1'b0;
    req = 2'b11; op = 2'b00; wdata0 = 16'h042D; wdata1 = 16'h07FF;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("rr_gnt", gnt, (c == 1 || c == 7) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00);
      check("rr_valid", rsp_valid, (c == 2 || c == 5 || c == 8));
      if (c == 2 || c == 5 || c == 8) begin
        check("rr_id", rsp_id, (c == 5));
        check("rr_data", rsp_data, (c == 5) ? 16'hFFFF : 16'h84DE);
      end
    end
    req = 2'b00;
    mdl_last = 1'b0;

    for (int i = 0; i < 10; i++)
      transact(tbl[i].r, tbl[i].o, tbl[i].w0, tbl[i].w1, tbl[i].g, tbl[i].d, tbl[i].s);

    // Reset asserted while the granted operation is in EXEC.
    req = 2'b01; op = 2'b01; wdata0 = 16'h80DE;
    @(negedge clk);
    check("abort_gnt_seen", gnt, 2'b01);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_gnt", gnt, 2'b00);
    check("abort_corr", corr_cnt, 0);
    check("abort_dbl", dbl_cnt, 0);
    @(negedge clk);
    rst = 1'b0; req = 2'b00;
    m_corr = 0; m_dbl = 0; mdl_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    transact(2'b01, 2'b00, 16'h042D, 16'h0, 2'b01, 16'h84DE, 2'b00);

    for (int it = 0; it < 200; it++) begin
      r  = 2'($urandom_range(1, 3));
      o  = 2'($urandom_range(0, 3));
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      if (o[0] && $urandom_range(0, 3) != 0) begin
        w0 = m_encode(11'($urandom));
        for (int f = $urandom_range(0, 2); f > 0; f--) w0[$urandom_range(0, 15)] ^= 1'b1;
      end
      if (o[1] && $urandom_range(0, 3) != 0) begin
        w1 = m_encode(11'($urandom));
        for (int f = $urandom_range(0, 2); f > 0; f--) w1[$urandom_range(0, 15)] ^= 1'b1;
      end
      win  = (r == 2'b11) ? ~mdl_last : r[1];
      wsel = win ? w1 : w0;
      eg   = win ? 2'b10 : 2'b01;
      if (o[win]) begin
        m_decode(wsel, ed, es);
      end else begin
        ed = m_encode(wsel[10:0]);
        es = 2'b00;
      end
      transact(r, o, w0, w1, eg, ed, es);
    end

    // Counter saturation, then clear racing a corrected response.
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    m_corr = 0; m_dbl = 0;
    check("clr_corr", corr_cnt, 0);
    check("clr_dbl", dbl_cnt, 0);
    for (int i = 0; i < 260; i++)
      transact(2'b01, 2'b01, 16'h80DE, 16'h0, 2'b01, 16'h042D, 2'b01);
    check("sat_corr", corr_cnt, 8'd255);
    req = 2'b01; op = 2'b01; wdata0 = 16'h80DE;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    check("clr_race_valid", rsp_valid, 1'b1);
    check("clr_race_status", rsp_status, 2'b01);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_race_corr", corr_cnt, 0);
    check("clr_race_dbl", dbl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
